neuron_core_controller: RTL and testbench

Wishbone-mapped sequencer that turns a host-written list of input-spike axon indices into timed, one-at-a-time packets for the 256x256 neuron core. It sits beside the synapse matrix, neuron parameter and spike-out blocks, occupying the pseudo-block at 0x3000C000 (addr[15:14] = 2'b11). It buffers events in a small FIFO and drives the axon select plus `new_image_packet` / `last_image_packet` flags. These flags mark the first and last packet of an image.

---
 rtl/neuron_ctrl_pkg.sv | 38 +++
 rtl/spike_event_fifo.sv | 68 ++++++
 rtl/neuron_core_controller.sv | 212 +++++++++++++++++++++
 tb/tb_neuron_core_controller.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_ctrl_pkg
// Description : Register map, STATUS layout and FSM encoding shared by the
//               neuron core controller and its spike-event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_ctrl_pkg;

    localparam int c_fifo_depth_default = 16;

    // Word offsets within the 16-byte window (byte address bits [3:2])
    localparam logic [1:0] c_off_push   = 2'd0;
    localparam logic [1:0] c_off_num    = 2'd1;
    localparam logic [1:0] c_off_ctrl   = 2'd2;
    localparam logic [1:0] c_off_status = 2'd3;

    localparam int c_ctrl_start = 0;
    localparam int c_ctrl_clear = 1;

    localparam int c_stat_busy    = 0;
    localparam int c_stat_done    = 1;
    localparam int c_stat_ovf     = 2;
    localparam int c_stat_empty   = 3;
    localparam int c_stat_full    = 4;
    localparam int c_stat_cnt_lsb = 8;
    localparam int c_stat_iss_lsb = 16;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle   = 3'd0;
    localparam state_t c_st_wait   = 3'd1;
    localparam state_t c_st_issue  = 3'd2;
    localparam state_t c_st_settle = 3'd3;
    localparam state_t c_st_done   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/spike_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spike_event_fifo
// Description : Synchronous FIFO with first-word-fall-through head; a push
//               while full is dropped based on the pre-pop occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_event_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/neuron_core_controller.sv
`default_nettype none
// ============================================================================
// Module      : neuron_core_controller
// Description : Wishbone register file plus sequencer that replays buffered
//               axon indices to the neuron core one packet every 3 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_core_controller
    import neuron_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000C000,
    parameter int          FIFO_DEPTH = c_fifo_depth_default
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  axon_idx_o,
    output logic        axon_valid_o,
    output logic        new_image_packet_o,
    output logic        last_image_packet_o,
    output logic        busy_o,
    output logic        done_irq_o
);

    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_ack;
    logic [31:0]     r_dat;
    logic [15:0]     r_num_spikes;
    logic [15:0]     r_issued;
    logic [7:0]      r_axon_idx;
    logic            r_start;
    logic            r_clear;
    logic            r_done;
    logic            r_overflow;

    logic            w_req;
    logic            w_hit;
    logic            w_wr;
    logic            w_rd;
    logic            w_idle;
    logic [1:0]      w_off;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [7:0]      w_head;
    logic [c_cw-1:0] w_count;
    logic [31:0]     w_status;
    logic [31:0]     w_rdata;
    logic            w_unused;

    assign w_unused = &{1'b0, wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i[31:16]};

    assign w_idle = (r_state == c_st_idle);
    assign w_off  = wbs_adr_i[3:2];
    assign w_hit  = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    // A new request is only taken while ack is low, so every access is 2 cycles
    assign w_req  = wbs_cyc_i & wbs_stb_i & ~r_ack;
    assign w_wr   = w_req & wbs_we_i & w_hit;
    assign w_rd   = w_req & ~wbs_we_i & w_hit;
    assign w_push = w_wr & (w_off == c_off_push);
    assign w_pop  = (r_state == c_st_wait) & ~w_empty;

    assign wbs_ack_o  = r_ack;
    assign wbs_dat_o  = r_dat;
    assign axon_idx_o = r_axon_idx;

    spike_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (wb_clk_i),
        .rst         (wb_rst_i),
        .i_push      (w_push),
        .i_push_data (wbs_dat_i[7:0]),
        .i_pop       (w_pop),
        .i_clear     (r_clear),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_comb begin
        w_status = '0;
        w_rdata  = '0;
        w_status[c_stat_busy]                = ~w_idle;
        w_status[c_stat_done]                = r_done;
        w_status[c_stat_ovf]                 = r_overflow;
        w_status[c_stat_empty]               = w_empty;
        w_status[c_stat_full]                = w_full;
        w_status[c_stat_cnt_lsb +: c_cw]     = w_count;
        w_status[c_stat_iss_lsb +: 16]       = r_issued;
        case (w_off)
            c_off_num:    w_rdata = {16'd0, r_num_spikes};
            c_off_status: w_rdata = w_status;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_req;
            r_dat <= w_rd ? w_rdata : 32'd0;
        end
    end

    // CTRL actions are registered so they land on the ack cycle
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_num_spikes <= '0;
            r_start      <= 1'b0;
            r_clear      <= 1'b0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_start <= w_wr & w_idle & (w_off == c_off_ctrl) & wbs_dat_i[c_ctrl_start];
            r_clear <= w_wr & w_idle & (w_off == c_off_ctrl) & wbs_dat_i[c_ctrl_clear];
            if (w_wr && w_idle && (w_off == c_off_num)) begin
                r_num_spikes <= wbs_dat_i[15:0];
            end
            if (r_clear) begin
                r_overflow <= 1'b0;
            end else if (w_push && w_full) begin
                r_overflow <= 1'b1;
            end
            if (r_clear) begin
                r_done <= 1'b0;
            end else if (r_state == c_st_done) begin
                r_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (r_start) begin
                    w_state_nxt = (r_num_spikes != 16'd0) ? c_st_wait : c_st_done;
                end
            end
            c_st_wait: begin
                if (!w_empty) begin
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_issue:  w_state_nxt = c_st_settle;
            c_st_settle: begin
                w_state_nxt = ((r_issued + 16'd1) == r_num_spikes) ? c_st_done : c_st_wait;
            end
            c_st_done:   w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        axon_valid_o        = 1'b0;
        new_image_packet_o  = 1'b0;
        last_image_packet_o = 1'b0;
        busy_o              = ~w_idle;
        done_irq_o          = 1'b0;
        case (r_state)
            c_st_issue: begin
                axon_valid_o        = 1'b1;
                new_image_packet_o  = (r_issued == 16'd0);
                last_image_packet_o = (r_issued == (r_num_spikes - 16'd1));
            end
            c_st_done:  done_irq_o = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_issued   <= '0;
            r_axon_idx <= '0;
        end else begin
            if (w_idle && r_start && (r_num_spikes != 16'd0)) begin
                r_issued <= '0;
            end else if (r_state == c_st_settle) begin
                r_issued <= r_issued + 16'd1;
            end
            if (w_pop) begin
                r_axon_idx <= w_head;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuron_core_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_core_controller
// Description : Self-checking bench: register vector table, directed image
//               sequences and randomized images against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_core_controller;

    localparam logic [31:0] A_PUSH = 32'h3000C000;
    localparam logic [31:0] A_NUM  = 32'h3000C004;
    localparam logic [31:0] A_CTRL = 32'h3000C008;
    localparam logic [31:0] A_STAT = 32'h3000C00C;

    logic        wb_clk_i  = 1'b0;
    logic        wb_rst_i  = 1'b1;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i  = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [7:0]  axon_idx_o;
    logic        axon_valid_o;
    logic        new_image_packet_o;
    logic        last_image_packet_o;
    logic        busy_o;
    logic        done_irq_o;

    neuron_core_controller #(
        .BASE_ADDR  (32'h3000C000),
        .FIFO_DEPTH (16)
    ) dut (
        .wb_clk_i            (wb_clk_i),
        .wb_rst_i            (wb_rst_i),
        .wbs_cyc_i           (wbs_cyc_i),
        .wbs_stb_i           (wbs_stb_i),
        .wbs_we_i            (wbs_we_i),
        .wbs_sel_i           (wbs_sel_i),
        .wbs_adr_i           (wbs_adr_i),
        .wbs_dat_i           (wbs_dat_i),
        .wbs_ack_o           (wbs_ack_o),
        .wbs_dat_o           (wbs_dat_o),
        .axon_idx_o          (axon_idx_o),
        .axon_valid_o        (axon_valid_o),
        .new_image_packet_o  (new_image_packet_o),
        .last_image_packet_o (last_image_packet_o),
        .busy_o              (busy_o),
        .done_irq_o          (done_irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [7:0] idx;
        logic       nw;
        logic       last;
        int         cyc;
    } pkt_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    pkt_t pkts[$];
    int   cyc_n    = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   n_chk    = 0;
    int   n_pass   = 0;

    always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

    always @(negedge wb_clk_i) begin
        if (axon_valid_o) begin
            pkts.push_back('{idx: axon_idx_o, nw: new_image_packet_o,
                             last: last_image_packet_o, cyc: cyc_n});
        end
        if (done_irq_o) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc_n;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Called at a negedge with ack low; returns two negedges later.
    task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      output logic [31:0] rdat, output logic ack1, output logic ack2);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        @(negedge wb_clk_i);
        ack1 = wbs_ack_o;
        rdat = wbs_dat_o;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(negedge wb_clk_i);
        ack2 = wbs_ack_o;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        logic a1, a2;
        wb(1'b1, adr, dat, d, a1, a2);
    endtask

    task automatic rd(input logic [31:0] adr, output logic [31:0] dat);
        logic a1, a2;
        wb(1'b0, adr, 32'd0, dat, a1, a2);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < budget) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", budget);
        end
        repeat (2) @(negedge wb_clk_i);
    endtask

    task automatic wait_pkts(input int target, input int budget);
        int n;
        n = 0;
        while (pkts.size() < target && n < budget) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            $display("FAIL wait_pkts: have %0d packets, required %0d", pkts.size(), target);
        end
    endtask

    logic [7:0] mq[$];
    logic [7:0] exp_pkts[$];
    logic [7:0] pushes[$];
    vec_t       vecs[$];

    initial begin
        logic [31:0] rdv;
        logic        a1, a2;
        int          t, p0, d0, q, n, need, extra, total, m;
        logic [31:0] es;

        repeat (3) @(negedge wb_clk_i);
        check("reset_outputs", {wbs_ack_o, wbs_dat_o, axon_idx_o, axon_valid_o, new_image_packet_o,
                                last_image_packet_o, busy_o, done_irq_o}, 64'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);

        // ---------------- register vector table ----------------
        vecs.push_back('{1'b0, A_STAT, 32'd0,          1'b1, 32'h0000_0008, "rst_status"});
        vecs.push_back('{1'b0, A_NUM,  32'd0,          1'b1, 32'h0000_0000, "rst_num"});
        vecs.push_back('{1'b1, A_NUM,  32'hDEAD_0005,  1'b0, 32'h0,         "num_wr"});
        vecs.push_back('{1'b0, A_NUM,  32'd0,          1'b1, 32'h0000_0005, "num_rd"});
        vecs.push_back('{1'b1, A_PUSH, 32'h0000_01AB,  1'b0, 32'h0,         "push_ab"});
        vecs.push_back('{1'b0, A_PUSH, 32'd0,          1'b1, 32'h0000_0000, "push_rd0"});
        vecs.push_back('{1'b0, A_STAT, 32'd0,          1'b1, 32'h0000_0100, "stat_cnt1"});
        vecs.push_back('{1'b1, A_PUSH, 32'h0000_0022,  1'b0, 32'h0,         "push_22"});
        vecs.push_back('{1'b0, A_STAT, 32'd0,          1'b1, 32'h0000_0200, "stat_cnt2"});
        vecs.push_back('{1'b1, A_CTRL, 32'h0000_0002,  1'b0, 32'h0,         "clear"});
        vecs.push_back('{1'b0, A_STAT, 32'd0,          1'b1, 32'h0000_0008, "stat_cleared"});
        vecs.push_back('{1'b1, A_NUM,  32'h0000_0000,  1'b0, 32'h0,         "num_wr0"});
        vecs.push_back('{1'b0, A_NUM,  32'd0,          1'b1, 32'h0000_0000, "num_rd0"});
        for (int i = 0; i < vecs.size(); i++) begin
            wb(vecs[i].we, vecs[i].adr, vecs[i].wdat, rdv, a1, a2);
            check({vecs[i].name, "_ack"}, {a1, a2}, 2'b10);
            if (vecs[i].chk) check(vecs[i].name, rdv, vecs[i].exp);
        end

        // ---------------- basic image: 3, 17, 255 ----------------
        wr(A_PUSH, 32'd3);
        wr(A_PUSH, 32'd17);
        wr(A_PUSH, 32'd255);
        wr(A_NUM, 32'd3);
        p0 = pkts.size();
        d0 = done_cnt;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = A_CTRL; wbs_dat_i = 32'd1;
        t = cyc_n;
        @(negedge wb_clk_i);
        check("busy_t1", busy_o, 0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(negedge wb_clk_i);
        check("busy_t2", busy_o, 1);
        wait_idle(100);
        check("img1_npkts", pkts.size() - p0, 3);
        if (pkts.size() - p0 == 3) begin
            check("img1_idx",  {pkts[p0].idx, pkts[p0+1].idx, pkts[p0+2].idx}, {8'd3, 8'd17, 8'd255});
            check("img1_new",  {pkts[p0].nw, pkts[p0+1].nw, pkts[p0+2].nw}, 3'b100);
            check("img1_last", {pkts[p0].last, pkts[p0+1].last, pkts[p0+2].last}, 3'b001);
            check("img1_cyc0", pkts[p0].cyc - t, 3);
            check("img1_cyc1", pkts[p0+1].cyc - t, 6);
            check("img1_cyc2", pkts[p0+2].cyc - t, 9);
        end
        check("img1_done_cnt", done_cnt - d0, 1);
        check("img1_done_cyc", done_cyc - t, 11);
        rd(A_STAT, rdv);
        check("img1_status", rdv, 32'h0003_000A);

        // ---------------- zero-length image ----------------
        wr(A_CTRL, 32'd2);
        wr(A_NUM, 32'd0);
        p0 = pkts.size();
        d0 = done_cnt;
        t = cyc_n;
        wr(A_CTRL, 32'd1);
        wait_idle(20);
        check("zero_npkts", pkts.size() - p0, 0);
        check("zero_done_cnt", done_cnt - d0, 1);
        check("zero_done_cyc", done_cyc - t, 2);
        rd(A_STAT, rdv);
        check("zero_done_bit", rdv[1], 1);

        // ---------------- overflow ----------------
        wr(A_CTRL, 32'd2);
        for (int i = 0; i < 17; i++) wr(A_PUSH, 32'(i + 40));
        rd(A_STAT, rdv);
        check("ovf_status", rdv[15:0], 16'h1014);
        wr(A_CTRL, 32'd2);
        rd(A_STAT, rdv);
        check("ovf_cleared", rdv[15:0], 16'h0008);

        // ---------------- waiting on an empty FIFO ----------------
        wr(A_NUM, 32'd2);
        p0 = pkts.size();
        d0 = done_cnt;
        wr(A_CTRL, 32'd1);
        repeat (6) @(negedge wb_clk_i);
        check("wait_busy", busy_o, 1);
        check("wait_nopkt", pkts.size() - p0, 0);
        wr(A_PUSH, 32'd5);
        wait_pkts(p0 + 1, 30);
        if (pkts.size() > p0) check("wait_pkt0", {pkts[p0].idx, pkts[p0].nw, pkts[p0].last}, {8'd5, 2'b10});
        check("wait_busy2", busy_o, 1);
        wr(A_PUSH, 32'd9);
        wait_idle(50);
        check("wait_npkts", pkts.size() - p0, 2);
        if (pkts.size() - p0 == 2) check("wait_pkt1", {pkts[p0+1].idx, pkts[p0+1].nw, pkts[p0+1].last}, {8'd9, 2'b01});
        check("wait_done", done_cnt - d0, 1);

        // ---------------- writes while busy ----------------
        wr(A_NUM, 32'd2);
        p0 = pkts.size();
        d0 = done_cnt;
        wr(A_CTRL, 32'd1);
        wr(A_NUM, 32'd7);
        wr(A_CTRL, 32'd1);
        rd(A_NUM, rdv);
        check("busy_num_kept", rdv, 32'd2);
        wr(A_PUSH, 32'd11);
        wr(A_PUSH, 32'd12);
        wait_idle(50);
        check("busy_npkts", pkts.size() - p0, 2);
        check("busy_done", done_cnt - d0, 1);
        rd(A_STAT, rdv);
        check("busy_issued", rdv[31:16], 16'd2);

        // ---------------- reset mid-image ----------------
        wr(A_CTRL, 32'd2);
        wr(A_PUSH, 32'd77);
        wr(A_PUSH, 32'd78);
        wr(A_PUSH, 32'd79);
        wr(A_NUM, 32'd3);
        p0 = pkts.size();
        d0 = done_cnt;
        wr(A_CTRL, 32'd1);
        wait_pkts(p0 + 1, 30);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check("rst_mid_outputs", {wbs_ack_o, wbs_dat_o, axon_idx_o, axon_valid_o, new_image_packet_o,
                                  last_image_packet_o, busy_o, done_irq_o}, 64'd0);
        wb_rst_i = 1'b0;
        repeat (20) @(negedge wb_clk_i);
        check("rst_mid_nodone", done_cnt - d0, 0);
        check("rst_mid_npkts", pkts.size() - p0, 1);
        rd(A_STAT, rdv);
        check("rst_mid_status", rdv, 32'h0000_0008);

        // ---------------- randomized images vs queue model ----------------
        mq.delete();
        for (int it = 0; it < 20; it++) begin
            q     = mq.size();
            n     = int'($urandom_range(1, 6));
            need  = (n > q) ? n - q : 0;
            extra = int'($urandom_range(0, 2));
            total = need + extra;
            if (q + total > 16) total = 16 - q;
            m = int'($urandom_range(0, total));
            pushes.delete();
            for (int k = 0; k < total; k++) pushes.push_back(8'($urandom));
            for (int k = 0; k < total; k++) mq.push_back(pushes[k]);
            exp_pkts.delete();
            for (int k = 0; k < n; k++) exp_pkts.push_back(mq.pop_front());

            wr(A_NUM, 32'(n));
            for (int k = 0; k < m; k++) wr(A_PUSH, 32'(pushes[k]));
            p0 = pkts.size();
            d0 = done_cnt;
            wr(A_CTRL, 32'd1);
            for (int k = m; k < total; k++) wr(A_PUSH, 32'(pushes[k]));
            wait_idle(200);

            check("rnd_npkts", pkts.size() - p0, n);
            if (pkts.size() - p0 == n) begin
                for (int k = 0; k < n; k++) begin
                    check("rnd_idx", pkts[p0+k].idx, exp_pkts[k]);
                    check("rnd_flags", {pkts[p0+k].nw, pkts[p0+k].last}, {k == 0, k == n - 1});
                    if (k > 0) check("rnd_gap", (pkts[p0+k].cyc - pkts[p0+k-1].cyc) >= 3, 1);
                end
            end
            check("rnd_done", done_cnt - d0, 1);
            es = (32'(n) << 16) | (32'(mq.size()) << 8) | 32'h2
               | ((mq.size() == 0)  ? 32'h8  : 32'h0)
               | ((mq.size() == 16) ? 32'h10 : 32'h0);
            rd(A_STAT, rdv);
            check("rnd_status", rdv, es);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
